pwm_heartbeat_sequencer: RTL

//  Programmable segment sequencer that configures the PWM heartbeat-mode counter generator.

---
 rtl/pwm_heartbeat_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_heartbeat_sequencer.sv
// pwm_heartbeat_sequencer
//   Plays a small table of heartbeat segments onto the configuration inputs of one PWM
//   channel's heartbeat generator. Each entry holds a threshold pair, an update period,
//   an increment step and a repeat count. Playback runs entries 0..N-1 and can loop.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   start_i, stop_i        start playback (honoured in IDLE only), abort playback
//   loop_en_i              restart at entry 0 after the last entry (sampled live)
//   num_segments_i         active entry count, sampled when a start is accepted
//   cfg_*                  table write port (accepted in IDLE only)
//   threshold_counter_*_o, period_counter_o, increment_step_o
//                          generator configuration for the current segment
//   hb_enable_o            high while a segment is being driven
//   segment_idx_o          entry currently driven
//   busy_o, done_o         not idle; one-cycle completion pulse (non-looping only)
//   cfg_err_o              one-cycle pulse after a table write dropped while busy

module pwm_heartbeat_sequencer #(
    parameter int unsigned Resolution  = 16,
    parameter int unsigned Segments    = 4,
    parameter int unsigned RepeatWidth = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic                          loop_en_i,
    input  logic [$clog2(Segments):0]     num_segments_i,
    input  logic                          cfg_we_i,
    input  logic [$clog2(Segments)-1:0]   cfg_addr_i,
    input  logic [Resolution-1:0]         cfg_thr1_i,
    input  logic [Resolution-1:0]         cfg_thr2_i,
    input  logic [Resolution-1:0]         cfg_period_i,
    input  logic [Resolution-1:0]         cfg_step_i,
    input  logic [RepeatWidth-1:0]        cfg_repeat_i,
    output logic [Resolution-1:0]         threshold_counter_1_o,
    output logic [Resolution-1:0]         threshold_counter_2_o,
    output logic [Resolution-1:0]         period_counter_o,
    output logic [Resolution-1:0]         increment_step_o,
    output logic                          hb_enable_o,
    output logic [$clog2(Segments)-1:0]   segment_idx_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          cfg_err_o
);

    localparam int unsigned IdxW = $clog2(Segments);
    localparam int unsigned CntW = IdxW + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;

    logic [Resolution-1:0]  thr1_tab   [Segments];
    logic [Resolution-1:0]  thr2_tab   [Segments];
    logic [Resolution-1:0]  period_tab [Segments];
    logic [Resolution-1:0]  step_tab   [Segments];
    logic [RepeatWidth-1:0] repeat_tab [Segments];

    logic [1:0]             state_q, state_d;
    logic [IdxW-1:0]        idx_q;
    logic [CntW-1:0]        n_q;
    logic [CntW-1:0]        n_clamped;
    logic [Resolution-1:0]  cc_q;
    logic [RepeatWidth-1:0] rep_q;
    logic [RepeatWidth-1:0] rep_lim_q;
    logic                   tick;
    logic                   seg_end;
    logic                   last_seg;

    assign busy_o = (state_q != StIdle);

    always_comb begin
        // Zero requests a single segment; oversize requests are limited to the table.
        n_clamped = num_segments_i;
        if (num_segments_i == '0) begin
            n_clamped = CntW'(1);
        end else if (num_segments_i > CntW'(Segments)) begin
            n_clamped = CntW'(Segments);
        end

        // Equality compare: a period of all-ones never needs cc to wrap.
        tick     = (cc_q == period_counter_o);
        seg_end  = (state_q == StRun) && tick && (rep_q == rep_lim_q);
        last_seg = ({1'b0, idx_q} == (n_q - CntW'(1)));

        state_d = state_q;
        if (stop_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (start_i) state_d = StLoad;
                StLoad:  state_d = StRun;
                StRun:   if (seg_end) state_d = (last_seg && !loop_en_i) ? StIdle : StLoad;
                default: state_d = StIdle;
            endcase
        end
    end

    // Descriptor table; writes only land while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Segments; i++) begin
                thr1_tab[i]   <= '0;
                thr2_tab[i]   <= '0;
                period_tab[i] <= '0;
                step_tab[i]   <= '0;
                repeat_tab[i] <= '0;
            end
        end else if (cfg_we_i && (state_q == StIdle)) begin
            thr1_tab[cfg_addr_i]   <= cfg_thr1_i;
            thr2_tab[cfg_addr_i]   <= cfg_thr2_i;
            period_tab[cfg_addr_i] <= cfg_period_i;
            step_tab[cfg_addr_i]   <= cfg_step_i;
            repeat_tab[cfg_addr_i] <= cfg_repeat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q               <= StIdle;
            idx_q                 <= '0;
            n_q                   <= '0;
            cc_q                  <= '0;
            rep_q                 <= '0;
            rep_lim_q             <= '0;
            threshold_counter_1_o <= '0;
            threshold_counter_2_o <= '0;
            period_counter_o      <= '0;
            increment_step_o      <= '0;
            segment_idx_o         <= '0;
            hb_enable_o           <= 1'b0;
            done_o                <= 1'b0;
            cfg_err_o             <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_o    <= 1'b0;
            cfg_err_o <= cfg_we_i && (state_q != StIdle);

            if (stop_i) begin
                // Abort: config outputs keep their values, no completion pulse.
                hb_enable_o <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            idx_q <= '0;
                            n_q   <= n_clamped;
                        end
                    end
                    StLoad: begin
                        threshold_counter_1_o <= thr1_tab[idx_q];
                        threshold_counter_2_o <= thr2_tab[idx_q];
                        period_counter_o      <= period_tab[idx_q];
                        increment_step_o      <= step_tab[idx_q];
                        rep_lim_q             <= repeat_tab[idx_q];
                        segment_idx_o         <= idx_q;
                        hb_enable_o           <= 1'b1;
                        cc_q                  <= '0;
                        rep_q                 <= '0;
                    end
                    StRun: begin
                        if (tick) begin
                            cc_q  <= '0;
                            rep_q <= rep_q + RepeatWidth'(1);
                            if (rep_q == rep_lim_q) begin
                                if (!last_seg) begin
                                    idx_q <= idx_q + IdxW'(1);
                                end else if (loop_en_i) begin
                                    idx_q <= '0;
                                end else begin
                                    hb_enable_o <= 1'b0;
                                    done_o      <= 1'b1;
                                end
                            end
                        end else begin
                            cc_q <= cc_q + Resolution'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
